// File: rtl/div_seq_pkg.sv
// Shared encodings for the RV32M divide sequencer: op select, FSM states and
// handshake level constants.
package div_seq_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_S_IDLE   = 2'b00;
  localparam logic [1:0] DIV_S_BYZERO = 2'b01;
  localparam logic [1:0] DIV_S_ON     = 2'b10;
  localparam logic [1:0] DIV_S_END    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Bit 0 clear selects the signed flavour, bit 1 set selects the remainder.
  function automatic logic div_op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic div_op_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration on the {remainder, dividend} register:
// shift left, trial-subtract the divisor, shift in the quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_rd,
  input  logic [XLEN-1:0]   i_dvsr,
  output logic [2*XLEN-1:0] o_rd,
  output logic              o_qbit
);
  logic [XLEN:0] w_part;
  logic [XLEN:0] w_diff;

  // The bit shifted out of the remainder is kept so the compare is exact.
  assign w_part = i_rd[2*XLEN-1:XLEN-1];
  assign w_diff = w_part - {1'b0, i_dvsr};
  assign o_qbit = ~w_diff[XLEN];
  assign o_rd   = {(o_qbit ? w_diff[XLEN-1:0] : w_part[XLEN-1:0]),
                   i_rd[XLEN-2:0], o_qbit};
endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU): 32-step restoring
// divide with sign fix-up, divide-by-zero shortcut and pipeline stall request.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] opdata1_i,
  input  logic [XLEN-1:0] opdata2_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);
  localparam int CW = $clog2(ITER);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_dvsr;
  logic [2*XLEN-1:0] r_rd;
  logic              r_negq;
  logic              r_negr;
  logic [XLEN-1:0]   r_result;
  logic              r_ready;

  logic              w_sgn;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [2*XLEN-1:0] w_step_rd;
  logic              w_qbit;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_fixed;
  logic              w_go;

  assign w_go   = (start_i == DivStart) && !annul_i;
  assign w_sgn  = div_op_signed(op_i);
  assign w_abs1 = (w_sgn && opdata1_i[XLEN-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (w_sgn && opdata2_i[XLEN-1]) ? -opdata2_i : opdata2_i;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rd   (r_rd),
    .i_dvsr (r_dvsr),
    .o_rd   (w_step_rd),
    .o_qbit (w_qbit)
  );

  // Result of the final iteration is fixed up and registered directly.
  assign w_q     = r_negq ? -w_step_rd[XLEN-1:0] : w_step_rd[XLEN-1:0];
  assign w_r     = r_negr ? -w_step_rd[2*XLEN-1:XLEN] : w_step_rd[2*XLEN-1:XLEN];
  assign w_fixed = div_op_rem(r_op) ? w_r : w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_dvsr   <= '0;
      r_rd     <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DIV_S_IDLE: begin
          if (w_go) begin
            r_op  <= op_i;
            r_cnt <= '0;
            if (opdata2_i == '0) begin
              // Raw dividend is kept for the REM-by-zero result.
              r_state <= DIV_S_BYZERO;
              r_rd    <= {{XLEN{1'b0}}, opdata1_i};
              r_dvsr  <= '0;
              r_negq  <= 1'b0;
              r_negr  <= 1'b0;
            end else begin
              r_state <= DIV_S_ON;
              r_rd    <= {{XLEN{1'b0}}, w_abs1};
              r_dvsr  <= w_abs2;
              r_negq  <= w_sgn & (opdata1_i[XLEN-1] ^ opdata2_i[XLEN-1]);
              r_negr  <= w_sgn & opdata1_i[XLEN-1];
            end
          end
        end
        DIV_S_BYZERO: begin
          if (annul_i) begin
            r_state <= DIV_S_IDLE;
          end else begin
            r_state  <= DIV_S_END;
            r_ready  <= DivResultReady;
            r_result <= div_op_rem(r_op) ? r_rd[XLEN-1:0] : {XLEN{1'b1}};
          end
        end
        DIV_S_ON: begin
          if (annul_i) begin
            r_state <= DIV_S_IDLE;
          end else begin
            r_rd  <= w_step_rd;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(ITER-1)) begin
              r_state  <= DIV_S_END;
              r_ready  <= DivResultReady;
              r_result <= w_fixed;
            end
          end
        end
        default: begin
          if (annul_i || (start_i == DivStop)) begin
            r_state  <= DIV_S_IDLE;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    case (r_state)
      DIV_S_IDLE:             stallreq_o = w_go;
      DIV_S_ON, DIV_S_BYZERO: stallreq_o = ~annul_i;
      default:                stallreq_o = 1'b0;
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

  logic w_unused;
  assign w_unused = w_qbit;
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the RV32M divide resource: DIV, DIVU, REM, REMU.
- Sits beside the EX stage. EX raises start when ID has classified an instruction as the divide result class.
- The block runs a 32-iteration restoring divide and returns one 32-bit result.
- It stalls the pipeline while busy and implements the RISC-V divide-by-zero and overflow rules.

Parameters:
- XLEN, 32, operand/result width
- ITER, 32, number of shift-subtract iterations (must equal XLEN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- start_i  in  1  EX requests a divide; held high until ready_o is seen
- annul_i  in  1  cancel current/pending divide (flush)
- op_i  in  2  divide op select, encoding per package
- opdata1_i  in  XLEN  dividend (rs1 value after forwarding)
- opdata2_i  in  XLEN  divisor (rs2 value after forwarding)
- result_o  out  XLEN  quotient or remainder, valid when ready_o=1
- ready_o  out  1  result valid
- stallreq_o  out  1  pipeline stall request to the stall controller

Behaviour:
- Reset: rst is synchronous, active-high.
  - state=IDLE.
  - result_o=0, ready_o=0; all internal registers cleared.
  - stallreq_o=0.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - If start_i=1 and annul_i=0, latch op_i and the operands.
  - Divisor==0 -> BYZERO; otherwise -> ON with iteration count=0.
  - Otherwise remain in IDLE.
- Operand preparation (signed ops DIV/REM only, at latch time):
  - Take the two's-complement absolute value of each operand.
  - Record neg_q = sign1 XOR sign2 and neg_r = sign1.
  - Unsigned ops use the raw values with neg_q=neg_r=0.
- ON (one iteration per cycle):
  - Shift the 2*XLEN remainder:dividend register left by 1.
  - Trial-subtract the divisor from the upper half.
  - If no borrow, keep the difference and set quotient bit 1; else quotient bit 0.
  - After ITER iterations -> END.
- END entry, result selection:
  - Apply sign fix: quotient negated if neg_q, remainder negated if neg_r.
  - Select quotient for DIV/DIVU, remainder for REM/REMU.
  - Register into result_o and set ready_o=1.
- BYZERO: next cycle -> END with the fixed result:
  - DIV/DIVU -> 0xFFFFFFFF.
  - REM/REMU -> original dividend, unmodified.
- END:
  - Hold ready_o=1 and result_o stable while start_i=1.
  - When start_i=0 -> IDLE, with ready_o=0 and result_o=0 in the following cycle.
- Latency, start accepted at cycle T:
  - Normal: END at T+33, i.e. ready_o high in cycle T+33 (32 ON cycles).
  - Divisor zero: ready_o high at T+2.
- Overflow: signed DIV of 0x80000000 by 0xFFFFFFFF is not special-cased in RTL. The normal path must produce quotient 0x80000000 and remainder 0.
- stallreq_o (combinational):
  - 1 when (state==IDLE and start_i=1 and annul_i=0), or state is ON or BYZERO.
  - 0 in END and in IDLE otherwise.
- Annul:
  - annul_i=1 in ON, BYZERO or END -> IDLE next cycle; ready_o=0, result_o=0, stallreq_o deasserts immediately.
  - annul_i has priority over start_i and over iteration completion in the same cycle.
- Reset mid-operation: rst overrides all states and returns to IDLE next edge; no partial result is ever presented.
- Operand inputs are ignored after the latch; changes during ON must not affect the result.
- Back-to-back divides: a new start_i is recognised only after passing through IDLE, so at least one cycle with start_i=0 is required between operations.

Decomposition:
- Shared package (alongside the existing op/select defines) holds:
  - Divide op encoding: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - State encoding: IDLE=2'b00, BYZERO=2'b01, ON=2'b10, END=2'b11.
  - DivResultReady / DivResultNotReady, DivStart / DivStop constants.
- One natural sub-module: div_step.
  - Combinational single iteration: shift, trial subtract, quotient bit.
  - Instantiated once inside div_seq.

Test Plan:
- DIVU 100/7, start at T -> stallreq_o=1 for T..T+32; ready_o=1 at T+33; result_o=14. REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1).
- DIVU 5/0 -> ready_o at T+2, result 0xFFFFFFFF. REM 0x80000000/0 -> result 0x80000000.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000. REM same operands -> 0.
- Annul at T+10 of a DIV -> IDLE at T+11, stallreq_o=0 at T+10, ready_o never asserts. A subsequent start completes correctly at its own +33.
- rst pulsed at T+20 mid-divide -> all outputs 0 next cycle. Holding start_i low for one cycle, then DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF at +33.
